axi4l_cmd_mst: RTL and testbench

//  Upstream AXI4-Lite master feeding the GPIO slave (base 0x4000_0000; 0x0 GPIO IN, 0x8 GPIO OUT).

---
 rtl/axi4l_cmd_pkg.sv | 29 ++
 rtl/axi4l_wdog.sv | 37 +++
 rtl/axi4l_cmd_mst.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4l_cmd_mst.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_cmd_pkg.sv
// -----------------------------------------------------------------------------
// axi4l_cmd_pkg
// Shared types for the AXI4-Lite command master:
//   state_t      - master FSM states
//   resp_t       - AXI BRESP/RRESP encodings
//   AXI_PROT_DEF - AxPROT value driven on every request (unprivileged,
//                  secure, data access)
// -----------------------------------------------------------------------------
package axi4l_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] AXI_PROT_DEF = 3'b000;

endpackage

// File: rtl/axi4l_wdog.sv
// -----------------------------------------------------------------------------
// axi4l_wdog
// Cycle watchdog for the AXI4-Lite command master. Counts cycles while run is
// high; expired is raised during the LIMIT-th consecutive run cycle so the
// caller can leave its waiting state on the following edge.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  synchronous counter clear
//   run     in  count enable
//   expired out limit reached (combinational, qualified by run)
// -----------------------------------------------------------------------------
module axi4l_wdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/axi4l_cmd_mst.sv
// -----------------------------------------------------------------------------
// axi4l_cmd_mst
// AXI4-Lite master that turns a valid/ready command stream into single AXI4-Lite
// beats (one outstanding transaction) and returns one response per command.
// Request address = BASE_ADDR + cmd_addr with the two LSBs forced to zero.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/addr/wdata/wstrb     command payload (1 = write)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_resp          read data (0 for writes), BRESP/RRESP
//   rsp_timeout                 watchdog abort flag
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master interface
//
// Build option:
//   AXI4L_MST_TIMEOUT_EN  when defined, a watchdog aborts any transaction that
//                         waits TIMEOUT_CYC cycles on the slave, answering
//                         SLVERR with rsp_timeout=1. Debug use only: the abort
//                         withdraws valids without a handshake. When undefined
//                         the FSM waits indefinitely and rsp_timeout is 0.
// -----------------------------------------------------------------------------
module axi4l_cmd_mst
    import axi4l_cmd_pkg::*;
#(
    parameter int unsigned            ADDR_W      = 32,
    parameter int unsigned            DATA_W      = 32,
    parameter logic [ADDR_W-1:0]      BASE_ADDR   = ADDR_W'(32'h4000_0000),
    parameter int unsigned            TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_t                 state;
    state_t                 state_nx;

    logic [ADDR_W-1:0]      addr_sum;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W/8-1:0]    wstrb_q;
    logic                   aw_done;
    logic                   w_done;
    logic [DATA_W-1:0]      rdata_q;
    logic [1:0]             resp_q;
    logic                   abort;
    logic                   accept;

    assign addr_sum = BASE_ADDR + cmd_addr;
    assign accept   = (state == IDLE) && cmd_valid;

    // -------------------------------------------------------------------------
    // Optional watchdog
    // -------------------------------------------------------------------------
`ifdef AXI4L_MST_TIMEOUT_EN
    logic wd_run;
    logic wd_clear;
    logic tmo_q;

    assign wd_run   = (state == WR_AW_W) || (state == WR_B) ||
                      (state == RD_AR)   || (state == RD_R);
    assign wd_clear = (state == IDLE);

    axi4l_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (abort)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else if (abort) begin
            tmo_q <= 1'b1;
        end else if (accept) begin
            tmo_q <= 1'b0;
        end
    end

    assign rsp_timeout = tmo_q;
`else
    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx      = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;

        case (state)
            IDLE: begin
                // Gated by rst so no command is taken during the reset cycle.
                cmd_ready = !rst;
                if (cmd_valid) begin
                    state_nx = cmd_we ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                // AW and W complete independently; leave once both are done,
                // counting a handshake happening in this very cycle.
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
                    state_nx = WR_B;
                end
            end
            WR_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_nx = RSP;
                end
            end
            RD_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nx = RD_R;
                end
            end
            RD_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    state_nx = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Abort only redirects the next state; valids fall with the state
        // change rather than combinationally inside the expiring cycle.
        if (abort) begin
            state_nx = RSP;
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            state <= state_nx;

            if (accept) begin
                addr_q  <= {addr_sum[ADDR_W-1:2], 2'b00};
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end

            if (state == WR_AW_W) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_done <= 1'b1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    w_done <= 1'b1;
                end
            end

            if (abort) begin
                rdata_q <= '0;
                resp_q  <= RESP_SLVERR;
            end else if ((state == WR_B) && m_axi_bvalid) begin
                rdata_q <= '0;
                resp_q  <= m_axi_bresp;
            end else if ((state == RD_R) && m_axi_rvalid) begin
                rdata_q <= m_axi_rdata;
                resp_q  <= m_axi_rresp;
            end
        end
    end

    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

    assign m_axi_awaddr = addr_q;
    assign m_axi_awprot = AXI_PROT_DEF;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_arprot = AXI_PROT_DEF;

endmodule

// File: tb/tb_axi4l_cmd_mst.sv
// -----------------------------------------------------------------------------
// tb_axi4l_cmd_mst
// Directed self-checking bench for axi4l_cmd_mst with a small GPIO-style
// AXI4-Lite slave model (0x4000_0000 GPIO IN, 0x4000_0008 GPIO OUT) whose
// ready delays and response codes are set per scenario.
// -----------------------------------------------------------------------------
module tb_axi4l_cmd_mst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi4l_cmd_mst #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .BASE_ADDR   (32'h4000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // ---------------- slave model ----------------
    int unsigned aw_dly = 0;
    int unsigned w_dly  = 0;
    int unsigned ar_dly = 0;
    bit          ar_never = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] gpio_in  = '0;
    logic [31:0] gpio_out = '0;

    int unsigned aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_seen = 1'b0, w_seen = 1'b0;
    logic [31:0] aw_addr_l = '0, wdata_l = '0;
    logic [3:0]  wstrb_l = '0;
    logic        aw_hs, w_hs;
    logic [31:0] s_wa, s_wd;
    logic [3:0]  s_ws;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
    assign m_axi_wready  = m_axi_wvalid  && (w_cnt >= w_dly);
    assign m_axi_arready = m_axi_arvalid && !ar_never && (ar_cnt >= ar_dly);
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        m_axi_rdata  = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_seen <= 1'b1; aw_addr_l <= m_axi_awaddr; end
            if (w_hs)  begin w_seen <= 1'b1; wdata_l <= m_axi_wdata; wstrb_l <= m_axi_wstrb; end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if ((aw_seen || aw_hs) && (w_seen || w_hs) && !m_axi_bvalid) begin
                s_wa = aw_hs ? m_axi_awaddr : aw_addr_l;
                s_wd = w_hs ? m_axi_wdata : wdata_l;
                s_ws = w_hs ? m_axi_wstrb : wstrb_l;
                if (s_wa == 32'h4000_0008) gpio_out <= merge(gpio_out, s_wd, s_ws);
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= bresp_cfg;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rresp  <= rresp_cfg;
                m_axi_rdata  <= (m_axi_araddr == 32'h4000_0000) ? gpio_in :
                                (m_axi_araddr == 32'h4000_0008) ? gpio_out : 32'h0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0;
    logic [31:0] last_awaddr = '0, last_araddr = '0;
    logic [2:0]  last_awprot = '1, last_arprot = '1;

    always @(posedge clk) begin
        if (m_axi_awvalid) aw_hi++;
        if (m_axi_wvalid)  w_hi++;
        if (m_axi_arvalid) ar_hi++;
        if (m_axi_bvalid && m_axi_bready) b_hs++;
        if (aw_hs) begin last_awaddr = m_axi_awaddr; last_awprot = m_axi_awprot; end
        if (m_axi_arvalid && m_axi_arready) begin last_araddr = m_axi_araddr; last_arprot = m_axi_arprot; end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Issue one command, wait for its response (holding rsp_ready low for
    // 'hold' cycles while checking the response stays put), then consume it.
    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int hold, input logic [31:0] hold_rdata,
                          output logic [31:0] rdata, output logic [1:0] resp,
                          output logic tmo, output int lat);
        int n;
        rdata = 'x; resp = 'x; tmo = 'x; lat = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 200 cycles", rsp_valid);
            return;
        end
        rdata = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, hold_rdata, 1'b0})
                $display("FAIL rsp_hold[%0d]: valid/rdata/cmd_ready=%b/%h/%b required 1/%h/0",
                         i, rsp_valid, rsp_rdata, cmd_ready, hold_rdata);
            else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
        else n_pass++;
        n_checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 6'b0)
            $display("FAIL reset_handshakes: got %b required 000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid});
        else n_pass++;
        n_checks++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'b0)
            $display("FAIL reset_rsp: rdata/resp/tmo=%h/%b/%b required 0/00/0", rsp_rdata, rsp_resp, rsp_timeout);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        gpio_in = 32'h1234_5678;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        n_checks++;
        if (last_araddr !== 32'h4000_0000) $display("FAIL rd_araddr: got %h required 40000000", last_araddr);
        else n_pass++;
        n_checks++;
        if (last_arprot !== 3'b000) $display("FAIL rd_arprot: got %b required 000", last_arprot);
        else n_pass++;
        n_checks++;
        if ({rd, rs, tm} !== {32'h1234_5678, 2'b00, 1'b0})
            $display("FAIL rd_rsp: rdata/resp/tmo=%h/%b/%b required 12345678/00/0", rd, rs, tm);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL rd_latency: got %0d required 3", lat);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        do_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, rd, rs, tm, lat);
        n_checks++;
        if (last_awaddr !== 32'h4000_0008) $display("FAIL wr_awaddr: got %h required 40000008", last_awaddr);
        else n_pass++;
        n_checks++;
        if (last_awprot !== 3'b000) $display("FAIL wr_awprot: got %b required 000", last_awprot);
        else n_pass++;
        n_checks++;
        if (gpio_out !== 32'hDEAD_BEEF) $display("FAIL wr_gpio_out: got %h required deadbeef", gpio_out);
        else n_pass++;
        n_checks++;
        if ({rd, rs, tm} !== {32'h0, 2'b00, 1'b0})
            $display("FAIL wr_rsp: rdata/resp/tmo=%h/%b/%b required 0/00/0", rd, rs, tm);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL wr_latency: got %0d required 3", lat);
        else n_pass++;
        // Unaligned offset 0xB must be issued as 0x4000_0008.
        do_cmd(1'b0, 32'hB, 32'h0, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        n_checks++;
        if (last_araddr !== 32'h4000_0008) $display("FAIL align_araddr: got %h required 40000008", last_araddr);
        else n_pass++;
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL readback: got %h required deadbeef", rd);
        else n_pass++;
    endtask

    task automatic test_aw_delay();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        int aw0, w0, b0;
        aw_dly = 2;
        aw0 = aw_hi; w0 = w_hi; b0 = b_hs;
        do_cmd(1'b1, 32'h8, 32'hCAFE_F00D, 4'b0011, 0, 32'h0, rd, rs, tm, lat);
        aw_dly = 0;
        n_checks++;
        if (aw_hi - aw0 !== 3) $display("FAIL awvalid_cycles: got %0d required 3", aw_hi - aw0);
        else n_pass++;
        n_checks++;
        if (w_hi - w0 !== 1) $display("FAIL wvalid_cycles: got %0d required 1", w_hi - w0);
        else n_pass++;
        n_checks++;
        if (b_hs - b0 !== 1) $display("FAIL b_beats: got %0d required 1", b_hs - b0);
        else n_pass++;
        n_checks++;
        if (gpio_out !== 32'hDEAD_F00D) $display("FAIL strb_gpio_out: got %h required deadf00d", gpio_out);
        else n_pass++;
        n_checks++;
        if (lat !== 5) $display("FAIL awdly_latency: got %0d required 5", lat);
        else n_pass++;
    endtask

    task automatic test_rsp_backpressure();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        gpio_in = 32'hA5A5_0F0F;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 5, 32'hA5A5_0F0F, rd, rs, tm, lat);
        n_checks++;
        if ({rd, rs} !== {32'hA5A5_0F0F, 2'b00}) $display("FAIL bp_rsp: rdata/resp=%h/%b required a5a50f0f/00", rd, rs);
        else n_pass++;
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL bp_after: cmd_ready/rsp_valid=%b/%b required 1/0", cmd_ready, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_error_resp();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        bresp_cfg = 2'b10;
        do_cmd(1'b1, 32'h8, 32'h1111_2222, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        bresp_cfg = 2'b00;
        n_checks++;
        if (rs !== 2'b10) $display("FAIL slverr_bresp: got %b required 10", rs);
        else n_pass++;
        n_checks++;
        if (gpio_out !== 32'hDEAD_F00D) $display("FAIL strb0_gpio_out: got %h required deadf00d", gpio_out);
        else n_pass++;
        rresp_cfg = 2'b11;
        gpio_in = 32'h0F0F_1234;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        rresp_cfg = 2'b00;
        n_checks++;
        if ({rd, rs} !== {32'h0F0F_1234, 2'b11}) $display("FAIL decerr_rresp: rdata/resp=%h/%b required 0f0f1234/11", rd, rs);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        ar_never = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_axi_arvalid !== 1'b1) $display("FAIL mid_arvalid: got %b required 1", m_axi_arvalid);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready} !== 7'b0)
            $display("FAIL mid_reset_outputs: got %b required 0000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready});
        else n_pass++;
        rst = 1'b0;
        ar_never = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL post_reset_idle: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
        gpio_in = 32'h0BAD_F00D;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        n_checks++;
        if ({rd, rs, lat} !== {32'h0BAD_F00D, 2'b00, 32'd3})
            $display("FAIL post_reset_read: rdata/resp/lat=%h/%b/%0d required 0badf00d/00/3", rd, rs, lat);
        else n_pass++;
    endtask

`ifdef AXI4L_MST_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd; logic [1:0] rs; logic tm; int lat;
        int ar0;
        ar_never = 1'b1;
        ar0 = ar_hi;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        ar_never = 1'b0;
        n_checks++;
        if ({rd, rs, tm} !== {32'h0, 2'b10, 1'b1})
            $display("FAIL tmo_rsp: rdata/resp/tmo=%h/%b/%b required 0/10/1", rd, rs, tm);
        else n_pass++;
        n_checks++;
        if (ar_hi - ar0 !== 16) $display("FAIL tmo_arvalid_cycles: got %0d required 16", ar_hi - ar0);
        else n_pass++;
        n_checks++;
        if (lat !== 17) $display("FAIL tmo_latency: got %0d required 17", lat);
        else n_pass++;
        gpio_in = 32'h5555_AAAA;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, rd, rs, tm, lat);
        n_checks++;
        if ({rd, rs, tm} !== {32'h5555_AAAA, 2'b00, 1'b0})
            $display("FAIL tmo_recover: rdata/resp/tmo=%h/%b/%b required 5555aaaa/00/0", rd, rs, tm);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_aw_delay();
        test_rsp_backpressure();
        test_error_resp();
        test_reset_mid();
`ifdef AXI4L_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
